// File: rtl/audio_codec_pkg.sv
// rtl/audio_codec_pkg.sv - WM8731 power-up table, sequencer states and frame builder
package audio_codec_pkg;

  localparam int NUM_REGS = 11;

  typedef enum logic [2:0] {
    ST_STARTUP,
    ST_ISSUE,
    ST_WAIT,
    ST_CHECK,
    ST_GAP,
    ST_DONE,
    ST_FAIL
  } state_t;

  typedef struct packed {
    logic [6:0] addr;
    logic [8:0] val;
  } reg_entry_t;

  // Entry 0 resets the codec, the last entry activates the digital interface.
  localparam reg_entry_t REG_TABLE [NUM_REGS] = '{
    '{addr: 7'd15, val: 9'h000},
    '{addr: 7'd0,  val: 9'h017},
    '{addr: 7'd1,  val: 9'h017},
    '{addr: 7'd2,  val: 9'h079},
    '{addr: 7'd3,  val: 9'h079},
    '{addr: 7'd4,  val: 9'h012},
    '{addr: 7'd5,  val: 9'h000},
    '{addr: 7'd6,  val: 9'h000},
    '{addr: 7'd7,  val: 9'h042},
    '{addr: 7'd8,  val: 9'h000},
    '{addr: 7'd9,  val: 9'h001}
  };

  function automatic logic [23:0] build_frame(input logic [6:0] dev, input reg_entry_t e);
    return {dev, 1'b0, e.addr, e.val};
  endfunction

endpackage

// File: rtl/audio_codec_config_rom.sv
// rtl/audio_codec_config_rom.sv - combinational index to codec register entry lookup
module codec_reg_rom
  import audio_codec_pkg::*;
(
  input  logic [3:0] i_idx,
  output reg_entry_t o_entry
);

  localparam logic [3:0] LAST_IDX = 4'(NUM_REGS - 1);

  always_comb begin
    o_entry = '0;
    if (i_idx <= LAST_IDX) begin
      o_entry = REG_TABLE[i_idx];
    end
  end

endmodule

// File: rtl/audio_codec_config.sv
// rtl/audio_codec_config.sv - walks the codec register table through the I2C write controller
module audio_codec_config
  import audio_codec_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR       = 7'h1A,
  parameter int         STARTUP_CYCLES = 4096,
  parameter int         GAP_CYCLES     = 256,
  parameter int         TIMEOUT_CYCLES = 8191,
  parameter int         MAX_RETRIES    = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        reconfig,
  output logic        i2c_start,
  output logic [23:0] i2c_data,
  input  logic        i2c_done,
  input  logic        i2c_ack,
  output logic        busy,
  output logic        config_done,
  output logic        error,
  output logic [3:0]  fail_index
);

  localparam logic [15:0] STARTUP_LOAD = 16'(STARTUP_CYCLES - 1);
  localparam logic [15:0] GAP_LOAD     = 16'(GAP_CYCLES - 1);
  localparam logic [12:0] TMO_LOAD     = 13'(TIMEOUT_CYCLES);
  localparam logic [3:0]  MAX_TRIES    = 4'(MAX_RETRIES);
  localparam logic [3:0]  LAST_IDX     = 4'(NUM_REGS - 1);

  state_t      r_state, w_state_nxt;
  logic [15:0] r_cnt, w_cnt_nxt;
  logic [12:0] r_tmo, w_tmo_nxt;
  logic [3:0]  r_idx, w_idx_nxt;
  logic [3:0]  r_tries, w_tries_nxt;
  logic [3:0]  r_fail_idx, w_fail_nxt;
  logic        r_nack, w_nack_nxt;
  logic [23:0] r_frame;
  logic [3:0]  w_rom_idx;
  logic [3:0]  w_tries_inc;
  reg_entry_t  w_entry;

  // During reset the ROM is steered to entry 0 so the frame register takes its reset value.
  assign w_rom_idx   = reset_n ? r_idx : 4'd0;
  assign w_tries_inc = r_tries + 4'd1;

  codec_reg_rom u_rom (
    .i_idx   (w_rom_idx),
    .o_entry (w_entry)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_tmo_nxt   = r_tmo;
    w_idx_nxt   = r_idx;
    w_tries_nxt = r_tries;
    w_fail_nxt  = r_fail_idx;
    w_nack_nxt  = r_nack;
    i2c_start   = 1'b0;
    busy        = 1'b1;
    config_done = 1'b0;
    error       = 1'b0;
    case (r_state)
      ST_STARTUP, ST_GAP: begin
        if (r_cnt == 16'd0) w_state_nxt = ST_ISSUE;
        else                w_cnt_nxt   = r_cnt - 16'd1;
      end
      ST_ISSUE: begin
        i2c_start   = 1'b1;
        w_tmo_nxt   = TMO_LOAD;
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (i2c_done) begin
          w_nack_nxt  = !i2c_ack;
          w_state_nxt = ST_CHECK;
        end else begin
          w_tmo_nxt = r_tmo - 13'd1;
          if (r_tmo == 13'd1) begin
            w_nack_nxt  = 1'b1;
            w_state_nxt = ST_CHECK;
          end
        end
      end
      ST_CHECK: begin
        w_cnt_nxt = GAP_LOAD;
        if (!r_nack) begin
          w_tries_nxt = 4'd0;
          if (r_idx == LAST_IDX) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_idx_nxt   = r_idx + 4'd1;
            w_state_nxt = ST_GAP;
          end
        end else begin
          w_tries_nxt = w_tries_inc;
          if (w_tries_inc >= MAX_TRIES) begin
            w_fail_nxt  = r_idx;
            w_state_nxt = ST_FAIL;
          end else begin
            w_state_nxt = ST_GAP;
          end
        end
      end
      ST_DONE, ST_FAIL: begin
        busy        = 1'b0;
        config_done = (r_state == ST_DONE);
        error       = (r_state == ST_FAIL);
        if (reconfig) begin
          w_idx_nxt   = 4'd0;
          w_tries_nxt = 4'd0;
          w_fail_nxt  = 4'd0;
          w_cnt_nxt   = GAP_LOAD;
          w_state_nxt = ST_GAP;
        end
      end
      default: w_state_nxt = ST_STARTUP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= ST_STARTUP;
      r_cnt      <= STARTUP_LOAD;
      r_tmo      <= TMO_LOAD;
      r_idx      <= 4'd0;
      r_tries    <= 4'd0;
      r_fail_idx <= 4'd0;
      r_nack     <= 1'b0;
      r_frame    <= build_frame(DEV_ADDR, w_entry);
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_tmo      <= w_tmo_nxt;
      r_idx      <= w_idx_nxt;
      r_tries    <= w_tries_nxt;
      r_fail_idx <= w_fail_nxt;
      r_nack     <= w_nack_nxt;
      // Frame only changes on the way into ISSUE so the controller sees it stable for the whole write.
      if (w_state_nxt == ST_ISSUE) r_frame <= build_frame(DEV_ADDR, w_entry);
    end
  end

  assign i2c_data   = r_frame;
  assign fail_index = r_fail_idx;

endmodule
